map_query_arbiter: RTL and testbench

Shares the single combinational `Map` wall-lookup port among up to eight movers, such as ghosts and the player sprite. Each mover presents a query coordinate and a level request. The arbiter grants one requester at a time, drives the shared `Map` address, and returns the registered wall bit with a one-cycle acknowledge pulse. It sits between the mover instances and the one `Map` instance in the top-level game datapath.

---
 rtl/map_query_arbiter.sv | 163 ++++++++++++++++
 tb/tb_map_query_arbiter.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/map_query_arbiter.sv
// Shares one combinational Map wall-lookup port among N_REQ movers; two-state IDLE/LOOK FSM.
// Optional MAP_ARB_RR_EN selects round-robin arbitration; otherwise fixed priority (index 0 highest).
module map_query_arbiter #(
    parameter int N_REQ = 4,
    parameter int XW    = 10,
    parameter int YW    = 9
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_REQ-1:0]      req,
    input  logic [N_REQ*XW-1:0]   req_x,
    input  logic [N_REQ*YW-1:0]   req_y,
    output logic [N_REQ-1:0]      ack,
    output logic                  rsp_wall,
    output logic [2:0]            grant_id,
    output logic                  busy,
    output logic [XW-1:0]         map_x,
    output logic [YW-1:0]         map_y,
    input  logic                  map_is_wall
);

    typedef enum logic {IDLE, LOOK} state_t;

    state_t                  state_q, state_d;
    logic [N_REQ-1:0]        ack_q, ack_d;
    logic                    rsp_wall_q, rsp_wall_d;
    logic [2:0]              grant_id_q, grant_id_d;
    logic                    busy_q, busy_d;
    logic [XW-1:0]           map_x_q, map_x_d;
    logic [YW-1:0]           map_y_q, map_y_d;

    logic [N_REQ-1:0][XW-1:0] lane_x;
    logic [N_REQ-1:0][YW-1:0] lane_y;
    logic [N_REQ-1:0]         elig;
    logic                     sel_vld;
    logic [2:0]               sel_idx;
    logic [XW-1:0]            sel_x;
    logic [YW-1:0]            sel_y;

    assign lane_x = req_x;
    assign lane_y = req_y;

`ifdef MAP_ARB_RR_EN
    logic [2:0] ptr_q, ptr_d;
    logic       hi_vld, lo_vld;
    logic [2:0] hi_idx, lo_idx;

    // Round-robin: lowest eligible index above ptr, else wrap to lowest eligible overall.
    always_comb begin
        elig    = req & ~ack_q;
        hi_vld  = 1'b0;
        hi_idx  = '0;
        lo_vld  = 1'b0;
        lo_idx  = '0;
        for (int i = N_REQ-1; i >= 0; i--) begin
            if (elig[i]) begin
                lo_vld = 1'b1;
                lo_idx = 3'(i);
                if (3'(i) > ptr_q) begin
                    hi_vld = 1'b1;
                    hi_idx = 3'(i);
                end
            end
        end
        sel_vld = hi_vld | lo_vld;
        sel_idx = hi_vld ? hi_idx : lo_idx;
    end
`else
    always_comb begin
        elig    = req & ~ack_q;
        sel_vld = 1'b0;
        sel_idx = '0;
        for (int i = N_REQ-1; i >= 0; i--) begin
            if (elig[i]) begin
                sel_vld = 1'b1;
                sel_idx = 3'(i);
            end
        end
    end
`endif

    always_comb begin
        sel_x = '0;
        sel_y = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (3'(i) == sel_idx) begin
                sel_x = lane_x[i];
                sel_y = lane_y[i];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        ack_d      = '0;
        rsp_wall_d = rsp_wall_q;
        grant_id_d = grant_id_q;
        busy_d     = busy_q;
        map_x_d    = map_x_q;
        map_y_d    = map_y_q;
`ifdef MAP_ARB_RR_EN
        ptr_d      = ptr_q;
`endif
        case (state_q)
            IDLE: begin
                if (sel_vld) begin
                    map_x_d    = sel_x;
                    map_y_d    = sel_y;
                    grant_id_d = sel_idx;
                    busy_d     = 1'b1;
                    state_d    = LOOK;
                end
            end
            LOOK: begin
                // Map address has been stable for a full cycle; capture its result.
                rsp_wall_d = map_is_wall;
                for (int i = 0; i < N_REQ; i++) begin
                    ack_d[i] = (3'(i) == grant_id_q);
                end
`ifdef MAP_ARB_RR_EN
                ptr_d      = grant_id_q;
`endif
                busy_d     = 1'b0;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            ack_q      <= '0;
            rsp_wall_q <= 1'b0;
            grant_id_q <= '0;
            busy_q     <= 1'b0;
            map_x_q    <= '0;
            map_y_q    <= '0;
`ifdef MAP_ARB_RR_EN
            ptr_q      <= 3'(N_REQ-1);
`endif
        end else begin
            state_q    <= state_d;
            ack_q      <= ack_d;
            rsp_wall_q <= rsp_wall_d;
            grant_id_q <= grant_id_d;
            busy_q     <= busy_d;
            map_x_q    <= map_x_d;
            map_y_q    <= map_y_d;
`ifdef MAP_ARB_RR_EN
            ptr_q      <= ptr_d;
`endif
        end
    end

    assign ack      = ack_q;
    assign rsp_wall = rsp_wall_q;
    assign grant_id = grant_id_q;
    assign busy     = busy_q;
    assign map_x    = map_x_q;
    assign map_y    = map_y_q;

endmodule

// File: tb/tb_map_query_arbiter.sv
// Directed bench for map_query_arbiter; the Map stand-in reports a wall where x and y share parity.
module tb_map_query_arbiter;
    localparam int N  = 4;
    localparam int XW = 10;
    localparam int YW = 9;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req;
    logic [N*XW-1:0] req_x;
    logic [N*YW-1:0] req_y;
    logic [N-1:0]    ack;
    logic            rsp_wall;
    logic [2:0]      grant_id;
    logic            busy;
    logic [XW-1:0]   map_x;
    logic [YW-1:0]   map_y;
    logic            map_is_wall;

    int errors = 0;
    int checks = 0;

    map_query_arbiter #(.N_REQ(N), .XW(XW), .YW(YW)) dut (
        .clk(clk), .rst(rst), .req(req), .req_x(req_x), .req_y(req_y),
        .ack(ack), .rsp_wall(rsp_wall), .grant_id(grant_id), .busy(busy),
        .map_x(map_x), .map_y(map_y), .map_is_wall(map_is_wall)
    );

    always #5 clk = ~clk;

    assign map_is_wall = (map_x[0] == map_y[0]);

    function automatic logic wall_of(input int x, input int y);
        return ((x % 2) == (y % 2));
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_coord(input int i, input int x, input int y);
        req_x[i*XW +: XW] = XW'(x);
        req_y[i*YW +: YW] = YW'(y);
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    // Waits (bounded) for the next ack pulse; idx stays -1 on timeout.
    task automatic wait_ack(output int idx, output int cyc, output logic [N-1:0] av);
        idx = -1;
        cyc = 0;
        av  = '0;
        for (int c = 1; c <= 12; c++) begin
            step();
            if (ack !== '0) begin
                av  = ack;
                cyc = c;
                for (int i = 0; i < N; i++) if (ack[i]) idx = i;
                return;
            end
        end
    endtask

    task automatic test_reset();
        req = '0; req_x = '0; req_y = '0;
        set_coord(2, 77, 33);
        apply_reset();
        checks++; if (ack !== 4'b0000)  begin errors++; $display("FAIL reset_ack: got %b want 0000", ack); end
        checks++; if (rsp_wall !== 1'b0) begin errors++; $display("FAIL reset_rsp: got %b want 0", rsp_wall); end
        checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (grant_id !== 3'd0) begin errors++; $display("FAIL reset_gid: got %0d want 0", grant_id); end
        checks++; if (map_x !== 10'd0 || map_y !== 9'd0)
            begin errors++; $display("FAIL reset_map: got %0d,%0d want 0,0", map_x, map_y); end
    endtask

    task automatic test_single();
        req = '0; req_x = '0; req_y = '0;
        apply_reset();
        req = 4'b0010;
        set_coord(1, 100, 50);
        step();
        checks++; if (map_x !== 10'd100 || map_y !== 9'd50)
            begin errors++; $display("FAIL single_addr: got %0d,%0d want 100,50", map_x, map_y); end
        checks++; if (busy !== 1'b1 || grant_id !== 3'd1 || ack !== 4'b0000)
            begin errors++; $display("FAIL single_grant: busy=%b gid=%0d ack=%b want 1,1,0000", busy, grant_id, ack); end
        step();
        checks++; if (ack !== 4'b0010 || rsp_wall !== 1'b1)
            begin errors++; $display("FAIL single_ack: ack=%b wall=%b want 0010,1", ack, rsp_wall); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy: got %b want 0", busy); end
        req = '0;
        step();
        checks++; if (ack !== 4'b0000 || rsp_wall !== 1'b1 || busy !== 1'b0)
            begin errors++; $display("FAIL single_after: ack=%b wall=%b busy=%b want 0000,1,0", ack, rsp_wall, busy); end
    endtask

    task automatic test_simultaneous();
        int idx, cyc, exp;
        logic [N-1:0] av;
        req = 4'b1001; req_x = '0; req_y = '0;
        set_coord(0, 5, 7);
        set_coord(3, 301, 200);
        apply_reset();
        for (int j = 0; j < 4; j++) begin
            wait_ack(idx, cyc, av);
            exp = (j % 2 == 0) ? 0 : 3;
            checks++; if (idx !== exp || !$onehot(av))
                begin errors++; $display("FAIL simul_idx[%0d]: got %0d (%b) want %0d", j, idx, av, exp); end
            checks++; if (map_x !== XW'(exp == 0 ? 5 : 301) || rsp_wall !== wall_of(exp == 0 ? 5 : 301, exp == 0 ? 7 : 200))
                begin errors++; $display("FAIL simul_data[%0d]: x=%0d wall=%b", j, map_x, rsp_wall); end
            if (j > 0) begin
                checks++; if (cyc !== 2) begin errors++; $display("FAIL simul_gap[%0d]: got %0d want 2", j, cyc); end
            end
        end
        req = '0;
    endtask

    task automatic test_fairness();
        int idx, cyc, exp;
        logic [N-1:0] av;
        req = 4'b1111; req_x = '0; req_y = '0;
        for (int i = 0; i < N; i++) set_coord(i, i*7 + 1, i*3);
        apply_reset();
        for (int j = 0; j < 8; j++) begin
            wait_ack(idx, cyc, av);
`ifdef MAP_ARB_RR_EN
            exp = j % 4;
`else
            exp = j % 2;
`endif
            checks++; if (idx !== exp || !$onehot(av))
                begin errors++; $display("FAIL fair_idx[%0d]: got %0d want %0d", j, idx, exp); end
            checks++; if (rsp_wall !== wall_of(exp*7 + 1, exp*3))
                begin errors++; $display("FAIL fair_wall[%0d]: got %b want %b", j, rsp_wall, wall_of(exp*7 + 1, exp*3)); end
        end
        req = '0;
    endtask

    // A lone requester is masked at its ack edge, so its queries land every third cycle.
    task automatic test_ack_exclusion();
        int idx, cyc;
        logic [N-1:0] av;
        req = '0; req_x = '0; req_y = '0;
        apply_reset();
        req = 4'b0100;
        set_coord(2, 10, 20);
        for (int j = 0; j < 4; j++) begin
            wait_ack(idx, cyc, av);
            checks++; if (idx !== 2 || av !== 4'b0100)
                begin errors++; $display("FAIL excl_idx[%0d]: got %b want 0100", j, av); end
            checks++; if (map_x !== XW'(10 + 3*j) || rsp_wall !== wall_of(10 + 3*j, 20))
                begin errors++; $display("FAIL excl_data[%0d]: x=%0d wall=%b want %0d,%b", j, map_x, rsp_wall, 10 + 3*j, wall_of(10 + 3*j, 20)); end
            checks++; if (cyc !== (j == 0 ? 2 : 3))
                begin errors++; $display("FAIL excl_gap[%0d]: got %0d want %0d", j, cyc, (j == 0 ? 2 : 3)); end
            set_coord(2, 10 + 3*(j+1), 20);
        end
        req = '0;
    endtask

    task automatic test_reset_mid_look();
        int idx, cyc;
        logic [N-1:0] av;
        req = '0; req_x = '0; req_y = '0;
        apply_reset();
        req = 4'b1111;
        set_coord(0, 4, 6);
        set_coord(1, 33, 44);
        set_coord(2, 8, 9);
        set_coord(3, 12, 13);
        step();
        step();
        checks++; if (ack !== 4'b0001 || rsp_wall !== 1'b1)
            begin errors++; $display("FAIL rmid_first: ack=%b wall=%b want 0001,1", ack, rsp_wall); end
        step();
        checks++; if (busy !== 1'b1 || grant_id !== 3'd1 || map_x !== 10'd33)
            begin errors++; $display("FAIL rmid_look: busy=%b gid=%0d x=%0d want 1,1,33", busy, grant_id, map_x); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++; if (ack !== 4'b0000 || rsp_wall !== 1'b0 || busy !== 1'b0)
            begin errors++; $display("FAIL rmid_out: ack=%b wall=%b busy=%b want 0000,0,0", ack, rsp_wall, busy); end
        checks++; if (map_x !== 10'd0 || map_y !== 9'd0 || grant_id !== 3'd0)
            begin errors++; $display("FAIL rmid_addr: x=%0d y=%0d gid=%0d want 0,0,0", map_x, map_y, grant_id); end
        wait_ack(idx, cyc, av);
        checks++; if (idx !== 0 || cyc !== 2)
            begin errors++; $display("FAIL rmid_next: got idx %0d after %0d want 0 after 2", idx, cyc); end
        req = '0;
    endtask

    task automatic test_priority();
        int idx, cyc, exp;
        logic [N-1:0] av;
        req = 4'b0111; req_x = '0; req_y = '0;
        for (int i = 0; i < N; i++) set_coord(i, 50 + i, 60);
        apply_reset();
        for (int j = 0; j < 6; j++) begin
            wait_ack(idx, cyc, av);
`ifdef MAP_ARB_RR_EN
            exp = j % 3;
`else
            exp = j % 2;
`endif
            checks++; if (idx !== exp)
                begin errors++; $display("FAIL prio_idx[%0d]: got %0d want %0d", j, idx, exp); end
        end
        req = '0;
    endtask

    initial begin
        rst = 1'b1; req = '0; req_x = '0; req_y = '0;
        test_reset();
        test_single();
        test_simultaneous();
        test_fairness();
        test_ack_exclusion();
        test_reset_mid_look();
        test_priority();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
